// File: rtl/alt_vipitc131_common_mode_sequencer.sv
// alt_vipitc131_common_mode_sequencer: arbitrates per-bank mode requests and commits them at frame boundaries.
// Define ALT_VIPITC131_MODE_TIMEOUT_EN to abandon a load that is not acknowledged within ACK_TIMEOUT cycles.
module alt_vipitc131_common_mode_sequencer #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int ACK_TIMEOUT      = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NO_OF_MODES-1:0]      mode_valid,
  input  logic [NO_OF_MODES-1:0]      mode_req,
  input  logic                        vid_eof,
  input  logic                        load_ack,
  output logic [NO_OF_MODES-1:0]      mode_onehot,
  output logic [LOG2_NO_OF_MODES-1:0] mode_binary,
  output logic                        load_req,
  output logic                        mode_change,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int N = NO_OF_MODES;
  localparam int L = LOG2_NO_OF_MODES;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [N-1:0] r_pend, r_onehot, w_onehot_nxt, w_gnt_oh;
  logic [L-1:0] r_bin, w_bin_nxt, r_last, w_last_nxt, w_lo, w_hi, w_gidx;
  logic r_load, w_load_nxt, r_chg, w_chg_nxt, w_hi_any, w_grant, w_clear;

  if ((1 << L) <= N || N < 2 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("alt_vipitc131_common_mode_sequencer: illegal parameter set");
  end

  // Round-robin: lowest pending index above last_grant, else lowest pending overall.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_hi_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_lo = L'(i);
      if (r_pend[i] && L'(i) > r_last) begin
        w_hi = L'(i);
        w_hi_any = 1'b1;
      end
    end
  end

  assign w_gidx   = w_hi_any ? w_hi : w_lo;
  assign w_gnt_oh = {{(N-1){1'b0}}, 1'b1} << w_gidx;

`ifdef ALT_VIPITC131_MODE_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] r_cnt;
  logic r_tout, w_tout_nxt, w_expired;
  assign w_expired = (r_cnt == TW'(ACK_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_cnt  <= (r_state == WAIT_ACK) ? r_cnt + 1'b1 : '0;
      r_tout <= w_tout_nxt;
    end
  assign timeout_err = r_tout;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_clear     = 1'b0;
    w_chg_nxt   = 1'b0;
    w_load_nxt  = r_load;
`ifdef ALT_VIPITC131_MODE_TIMEOUT_EN
    w_tout_nxt  = r_tout & enable;
`endif
    case (r_state)
      IDLE: w_grant = enable & (|r_pend);
      WAIT_ACK:
        if (load_ack) begin
          w_load_nxt  = 1'b0;
          w_chg_nxt   = 1'b1;
          w_state_nxt = RUN;
        end
`ifdef ALT_VIPITC131_MODE_TIMEOUT_EN
        else if (w_expired) begin
          w_load_nxt  = 1'b0;
          w_clear     = 1'b1;
          w_tout_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      RUN:
        if (vid_eof) begin
          if (!enable || !(|(mode_valid & r_onehot))) begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
          end else w_grant = |r_pend;
        end
      default: w_state_nxt = IDLE;
    endcase
    if (w_grant) begin
      w_state_nxt = WAIT_ACK;
      w_load_nxt  = 1'b1;
    end
  end

  assign w_onehot_nxt = w_grant ? w_gnt_oh : w_clear ? '0 : r_onehot;
  assign w_bin_nxt    = w_grant ? w_gidx + 1'b1 : w_clear ? '0 : r_bin;
  assign w_last_nxt   = w_grant ? w_gidx : r_last;

  // A request for the bank already on screen is dropped rather than queued.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_onehot <= '0;
      r_bin    <= '0;
      r_last   <= L'(N - 1);
      r_load   <= 1'b0;
      r_chg    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= mode_valid & ~r_onehot & ((r_pend & ~({N{w_grant}} & w_gnt_oh)) | mode_req);
      r_onehot <= w_onehot_nxt;
      r_bin    <= w_bin_nxt;
      r_last   <= w_last_nxt;
      r_load   <= w_load_nxt;
      r_chg    <= w_chg_nxt;
    end

  assign mode_onehot = r_onehot;
  assign mode_binary = r_bin;
  assign load_req    = r_load;
  assign mode_change = r_chg;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_alt_vipitc131_common_mode_sequencer.sv
// tb_alt_vipitc131_common_mode_sequencer: directed vector table plus reset and timeout sequences.
module tb_alt_vipitc131_common_mode_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, eof = 1'b0, ack = 1'b0;
  logic [2:0] val = 3'b000, req = 3'b000, oh;
  logic [1:0] bin;
  logic ld, chg, bsy, tout;
  int n_run = 0, n_fail = 0;

  alt_vipitc131_common_mode_sequencer #(
    .NO_OF_MODES(3), .LOG2_NO_OF_MODES(2), .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .mode_valid(val), .mode_req(req),
    .vid_eof(eof), .load_ack(ack), .mode_onehot(oh), .mode_binary(bin),
    .load_req(ld), .mode_change(chg), .busy(bsy), .timeout_err(tout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] i;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b ({oh,bin,ld,chg,busy,tout})", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {oh, bin, ld, chg, bsy, tout};
  endfunction

  initial begin
    logic held;
    // inputs {en,val,req,eof,ack} -> expected {onehot,binary,load_req,mode_change,busy}
    tbl.push_back({9'b1_111_010_0_0, 8'b000_00_0_0_0});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_1_0_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_1_0_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_1_0_1});
    tbl.push_back({9'b1_111_000_0_1, 8'b010_10_0_1_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_101_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_000_1_0, 8'b100_11_1_0_1});
    tbl.push_back({9'b1_111_000_0_1, 8'b100_11_0_1_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b100_11_0_0_1});
    tbl.push_back({9'b1_111_000_1_0, 8'b001_01_1_0_1});
    tbl.push_back({9'b1_111_000_0_1, 8'b001_01_0_1_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b001_01_0_0_1});
    tbl.push_back({9'b1_111_010_0_0, 8'b001_01_0_0_1});
    tbl.push_back({9'b1_111_000_1_0, 8'b010_10_1_0_1});
    tbl.push_back({9'b1_111_000_0_1, 8'b010_10_0_1_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_010_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_000_1_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_001_1_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_111_000_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_101_000_0_0, 8'b010_10_0_0_1});
    tbl.push_back({9'b1_101_000_1_0, 8'b000_00_0_0_0});
    tbl.push_back({9'b1_101_000_0_0, 8'b001_01_1_0_1});
    tbl.push_back({9'b1_101_000_0_1, 8'b001_01_0_1_1});
    tbl.push_back({9'b1_101_000_0_1, 8'b001_01_0_0_1});
    tbl.push_back({9'b1_101_010_0_0, 8'b001_01_0_0_1});
    tbl.push_back({9'b1_101_000_1_0, 8'b001_01_0_0_1});
    tbl.push_back({9'b0_111_000_0_0, 8'b001_01_0_0_1});
    tbl.push_back({9'b0_111_000_1_0, 8'b000_00_0_0_0});
    tbl.push_back({9'b0_111_100_0_0, 8'b000_00_0_0_0});
    tbl.push_back({9'b1_111_000_0_0, 8'b100_11_1_0_1});

    step();
    step();
    chk("reset_hold", outs(), 9'b0);
    rst_n = 1'b1;
    step();
    chk("reset_release", outs(), 9'b0);

    foreach (tbl[k]) begin
      {en, val, req, eof, ack} = tbl[k].i;
      step();
      chk($sformatf("vec%0d", k), outs(), {tbl[k].e, 1'b0});
    end

    // In WAIT_ACK on bank 2 with bank 0 pending, reset must wipe everything at once.
    {en, val, req, eof, ack} = 9'b1_111_001_0_0;
    step();
    {en, val, req, eof, ack} = 9'b1_111_000_0_0;
    chk("pre_reset_wait_ack", outs(), 9'b100_11_1_0_1_0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 9'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("pend_lost_after_reset", outs(), 9'b0);

    // Grant with no acknowledge.
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    chk("to_grant", outs(), 9'b001_01_1_0_1_0);
`ifdef ALT_VIPITC131_MODE_TIMEOUT_EN
    for (int c = 0; c < 7; c++) step();
    chk("to_before_limit", outs(), 9'b001_01_1_0_1_0);
    step();
    chk("to_expired", outs(), 9'b000_00_0_0_0_1);
    step();
    chk("to_sticky", outs(), 9'b000_00_0_0_0_1);
    en = 1'b0;
    step();
    chk("to_cleared_by_enable", outs(), 9'b0);
`else
    held = 1'b1;
    for (int c = 0; c < 120; c++) begin
      step();
      if (outs() !== 9'b001_01_1_0_1_0) held = 1'b0;
    end
    chk("no_timeout_held", {8'b0, held}, 9'b1);
    chk("no_timeout_state", outs(), 9'b001_01_1_0_1_0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("late_ack", outs(), 9'b001_01_0_1_1_0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alt_vipitc131_common_mode_sequencer.md
# alt_vipitc131_common_mode_sequencer

Sequences video-mode switching for the clocked video output. The block arbitrates between per-bank mode-change requests and commits the winner only at a frame boundary. It runs a load/acknowledge handshake with the timing generator and drives the active mode as both a one-hot vector and a binary code. The binary code is the bank index plus one, with 0 meaning no mode. The block sits between the control-port mode banks and the timing generator.

## Interface
Parameters:
- NO_OF_MODES, 3, number of mode banks (N ≥ 2)
- LOG2_NO_OF_MODES, 2, binary code width L; must satisfy 2^L > N
- ACK_TIMEOUT, 1023, WAIT_ACK cycle limit; used only with the timeout macro

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  go bit
- mode_valid  in  N  bank i is programmed and usable
- mode_req  in  N  one-cycle pulse per bank requesting a switch to bank i
- vid_eof  in  1  one-cycle end-of-frame strobe from the timing generator
- load_ack  in  1  timing generator has loaded the presented mode
- mode_onehot  out  N  active bank, one-hot or all zero
- mode_binary  out  L  active bank index+1; 0 means none
- load_req  out  1  level; held high until acknowledged
- mode_change  out  1  one-cycle pulse when a switch completes
- busy  out  1  high when the state is not IDLE
- timeout_err  out  1  sticky acknowledge-timeout flag

## Operation
Pending register pend[N]:
- Set bit i when mode_req[i] & mode_valid[i].
- Clear bit i when mode_valid[i]=0. If a request and a valid drop arrive together, the valid drop wins.
- Clear bit i when bank i is granted.
- A request for the currently active bank clears the bit with no switch.

Arbitration:
- Round-robin over pend, searching from index (last_grant+1) mod N.
- last_grant resets to N-1, so the first search starts at index 0.

States:
- IDLE: all mode outputs 0. If enable & |pend → grant, go to WAIT_ACK.
- WAIT_ACK: load_req=1. If load_ack → load_req←0, mode_change←1 for one cycle, go to RUN.
  - load_ack is ignored in every other state.
  - enable changes and mode_valid drops are deferred until RUN.
- RUN: acts only on a cycle with vid_eof=1, in this priority order:
  - If !enable or !mode_valid[cur] → go to IDLE, clear the mode outputs, no mode_change pulse.
  - Else if |pend → grant, go to WAIT_ACK.
  - Else stay in RUN.

Grant, registered on one edge:
- mode_onehot ← the granted bit.
- mode_binary ← granted index+1.
- load_req ← 1.
- last_grant ← granted index.
- pend bit cleared.

Reset mid-operation: all outputs and registers return to their reset values immediately, and pending requests are lost.

## Timing
- Reset values:
  - mode_onehot=0, mode_binary=0, load_req=0, mode_change=0, busy=0, timeout_err=0
  - state=IDLE, pend=0, last_grant=N-1
- Grant latency:
  - From IDLE: pend set at edge E → outputs valid after edge E+1.
  - From RUN: vid_eof sampled at edge T → new mode_onehot, mode_binary and load_req visible after edge T.
- Handshake:
  - load_ack may arrive in the first WAIT_ACK cycle. mode_change then pulses after the next edge, so minimum eof-to-mode_change latency is 2 edges.
  - load_req never drops without load_ack, except on timeout or reset.
- A mode_req in the same cycle as vid_eof is not eligible for that eof. pend is registered first.
- mode_onehot and mode_binary always encode the same bank: binary = position+1.

## Configuration
- ALT_VIPITC131_MODE_TIMEOUT_EN defined:
  - A counter runs in WAIT_ACK, cleared on entry.
  - After ACK_TIMEOUT cycles without load_ack: load_req←0, mode outputs←0, timeout_err←1, go to IDLE.
  - timeout_err is cleared by reset or by enable=0.
- Not defined:
  - WAIT_ACK waits indefinitely.
  - The counter is not built.
  - timeout_err is tied to 0.

## Test plan
All scenarios use N=3, L=2.
- Reset: assert rst_n=0 mid-WAIT_ACK → all outputs 0 immediately; after release, still 0 with state IDLE.
- Startup: enable=1, mode_req=3'b010 in IDLE → next cycle mode_onehot=010, mode_binary=2, load_req=1, busy=1; load_ack 3 cycles later → load_req=0, one-cycle mode_change, state RUN.
- Round-robin: active bank 1, pend=3'b101 → 1st eof grants bank 2 (binary 3); after its ack, 2nd eof grants bank 0 (binary 1).
- Self-request: in RUN on bank 1, pulse mode_req=3'b010 then vid_eof → no load_req, no mode_change, pend=0.
- Drop: clear mode_valid[1] while running on bank 1, then vid_eof → mode_onehot=0, mode_binary=0, busy=0, no mode_change.
- Timeout, ACK_TIMEOUT=8, macro defined: no load_ack → after 8 WAIT_ACK cycles load_req=0, outputs 0, timeout_err=1. Without the macro, load_req stays high for 100+ cycles and timeout_err=0.
